// File: rtl/stb_seq_pkg.sv
// Shared types for the strobe-generator sequencing controller.
package stb_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRST     = 3'd1,
        ARM      = 3'd2,
        WAIT_RDY = 3'd3,
        REQ      = 3'd4,
        WAIT_VLD = 3'd5,
        DONE     = 3'd6,
        FAIL     = 3'd7
    } stb_seq_state_e;

    typedef enum logic [1:0] {
        FAIL_NONE = 2'd0,
        FAIL_TMO  = 2'd1,
        FAIL_DET  = 2'd2,
        FAIL_LOST = 2'd3
    } stb_fail_e;

    // A sequence is in progress everywhere except the three resting states.
    function automatic logic is_active(input stb_seq_state_e s);
        return !(s inside {IDLE, DONE, FAIL});
    endfunction

endpackage

// File: rtl/stb_seq_timer.sv
// Loadable up-counter with terminal compare; load restarts the count at 1,
// so hit_o is high during the limit_i-th clock after the load.
module stb_seq_timer #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         load_i,
    input  logic [W-1:0] limit_i,
    output logic         hit_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign hit_o = (cnt_q == limit_i);

    // Holding at the terminal value keeps a reached limit from wrapping away.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(1);
        end else if (!hit_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stb_seq_ctrl.sv
// Sequencing controller for one stb_gen: reset, detect with retry, latch period,
// then issue the programmed number of strobe requests.
module stb_seq_ctrl
    import stb_seq_pkg::*;
#(
    parameter int T_CNT_WIDTH = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int RST_CYC     = 4,
    parameter int RUN_CYC     = 42,
    parameter int MAX_RETRY   = 3
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [CNT_WIDTH-1:0]   cfg_nstb_i,
    input  logic [T_CNT_WIDTH-1:0] cfg_timeout_i,
    output logic                   gen_arst_o,
    output logic                   run_det_o,
    output logic                   oe_o,
    output logic                   stb_req_o,
    input  logic                   rdy_i,
    input  logic                   err_i,
    input  logic                   stb_valid_i,
    input  logic [T_CNT_WIDTH-1:0] stb_period_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   fail_o,
    output logic [1:0]             fail_code_o,
    output logic [T_CNT_WIDTH-1:0] period_o,
    output logic                   period_vld_o,
    output logic [CNT_WIDTH-1:0]   stb_cnt_o,
    output stb_seq_state_e         dbg_state_o
);

    stb_seq_state_e         state_q, state_d;
    logic [2:0]             retry_q, retry_d;
    logic [CNT_WIDTH-1:0]   nstb_q, nstb_d;
    logic [T_CNT_WIDTH-1:0] tmo_q, tmo_d;
    logic [T_CNT_WIDTH-1:0] period_q, period_d;
    logic                   period_vld_q, period_vld_d;
    logic [CNT_WIDTH-1:0]   stb_cnt_q, stb_cnt_d;
    logic                   fail_q, fail_d;
    stb_fail_e              fail_code_q, fail_code_d;
    logic                   done_q, done_d;
    logic                   busy_q;
    logic                   gen_arst_q, run_det_q, oe_q, stb_req_q;

    logic [T_CNT_WIDTH-1:0] tmr_limit;
    logic                   tmr_hit;
    logic                   tmo_hit;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    assign tmr_limit = (state_q == GRST) ? T_CNT_WIDTH'(RST_CYC) :
                       (state_q == ARM)  ? T_CNT_WIDTH'(RUN_CYC) : tmo_q;
    assign tmo_hit   = tmr_hit && (tmo_q != '0);
    assign cnt_inc   = (stb_cnt_q == '1) ? stb_cnt_q : stb_cnt_q + CNT_WIDTH'(1);

    stb_seq_timer #(.W(T_CNT_WIDTH)) u_timer (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .load_i  (state_d != state_q),
        .limit_i (tmr_limit),
        .hit_o   (tmr_hit)
    );

    // Handshake: stb_req_o is a one-clock request; the generator answers with a
    // one-clock stb_valid_i, which may coincide with the request clock itself.
    // Only one request is outstanding because REQ is re-entered only after valid.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        nstb_d       = nstb_q;
        tmo_d        = tmo_q;
        period_d     = period_q;
        period_vld_d = period_vld_q;
        stb_cnt_d    = stb_cnt_q;
        fail_d       = fail_q;
        fail_code_d  = fail_code_q;
        done_d       = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE, FAIL: begin
                    if (start_i) begin
                        state_d      = GRST;
                        fail_d       = 1'b0;
                        fail_code_d  = FAIL_NONE;
                        period_vld_d = 1'b0;
                        stb_cnt_d    = '0;
                        retry_d      = '0;
                        nstb_d       = cfg_nstb_i;
                        tmo_d        = cfg_timeout_i;
                    end
                end
                GRST: if (tmr_hit) state_d = ARM;
                ARM:  if (tmr_hit) state_d = WAIT_RDY;
                WAIT_RDY: begin
                    if (err_i || (!rdy_i && tmo_hit)) begin
                        if (retry_q < 3'(MAX_RETRY)) begin
                            retry_d = retry_q + 3'd1;
                            state_d = GRST;
                        end else begin
                            state_d     = FAIL;
                            fail_d      = 1'b1;
                            fail_code_d = err_i ? FAIL_DET : FAIL_TMO;
                        end
                    end else if (rdy_i) begin
                        period_d     = stb_period_i;
                        period_vld_d = 1'b1;
                        state_d      = REQ;
                    end
                end
                REQ: state_d = WAIT_VLD;
                WAIT_VLD: begin
                    if (err_i || !rdy_i) begin
                        state_d     = FAIL;
                        fail_d      = 1'b1;
                        fail_code_d = FAIL_LOST;
                    end else if (stb_valid_i) begin
                        stb_cnt_d = cnt_inc;
                        if ((nstb_q != '0) && (cnt_inc == nstb_q)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
                    end else if (tmo_hit) begin
                        state_d     = FAIL;
                        fail_d      = 1'b1;
                        fail_code_d = FAIL_TMO;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Generator controls are registered from the current state, so they trail it by a clock.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q      <= IDLE;
            retry_q      <= '0;
            nstb_q       <= '0;
            tmo_q        <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            stb_cnt_q    <= '0;
            fail_q       <= 1'b0;
            fail_code_q  <= FAIL_NONE;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            gen_arst_q   <= 1'b0;
            run_det_q    <= 1'b0;
            oe_q         <= 1'b0;
            stb_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            nstb_q       <= nstb_d;
            tmo_q        <= tmo_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            stb_cnt_q    <= stb_cnt_d;
            fail_q       <= fail_d;
            fail_code_q  <= fail_code_d;
            done_q       <= done_d;
            busy_q       <= is_active(state_d);
            gen_arst_q   <= (state_q != GRST);
            run_det_q    <= (state_q == ARM);
            oe_q         <= (state_q == REQ) || (state_q == WAIT_VLD);
            stb_req_q    <= (state_q == REQ);
        end
    end

    assign gen_arst_o   = gen_arst_q;
    assign run_det_o    = run_det_q;
    assign oe_o         = oe_q;
    assign stb_req_o    = stb_req_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fail_o       = fail_q;
    assign fail_code_o  = fail_code_q;
    assign period_o     = period_q;
    assign period_vld_o = period_vld_q;
    assign stb_cnt_o    = stb_cnt_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_stb_seq_ctrl.sv
// Bench for stb_seq_ctrl: scenario table run against a reactive generator model,
// plus hand-written reset and abort sequences.
module tb_stb_seq_ctrl;
    import stb_seq_pkg::*;

    localparam int TW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic arst_i = 1'b0;
    logic start_i = 1'b0;
    logic abort_i = 1'b0;
    logic [CW-1:0] cfg_nstb_i = '0;
    logic [TW-1:0] cfg_timeout_i = '0;
    logic rdy_i = 1'b0;
    logic err_i = 1'b0;
    logic stb_valid_i = 1'b0;
    logic [TW-1:0] stb_period_i = '0;
    logic gen_arst_o, run_det_o, oe_o, stb_req_o;
    logic busy_o, done_o, fail_o, period_vld_o;
    logic [1:0] fail_code_o;
    logic [TW-1:0] period_o;
    logic [CW-1:0] stb_cnt_o;
    stb_seq_state_e dbg_state_o;

    stb_seq_ctrl #(
        .T_CNT_WIDTH(TW), .CNT_WIDTH(CW), .RST_CYC(4), .RUN_CYC(42), .MAX_RETRY(3)
    ) dut (
        .clk_i(clk), .arst_i(arst_i), .start_i(start_i), .abort_i(abort_i),
        .cfg_nstb_i(cfg_nstb_i), .cfg_timeout_i(cfg_timeout_i),
        .gen_arst_o(gen_arst_o), .run_det_o(run_det_o), .oe_o(oe_o), .stb_req_o(stb_req_o),
        .rdy_i(rdy_i), .err_i(err_i), .stb_valid_i(stb_valid_i), .stb_period_i(stb_period_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .fail_code_o(fail_code_o),
        .period_o(period_o), .period_vld_o(period_vld_o), .stb_cnt_o(stb_cnt_o),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Generator model knobs: lock on attempts >= m_rdy_from (0 = never), raise err
    // with rdy on attempts <= m_err_until, answer requests after m_lat clocks, and
    // drop rdy instead of answering once m_drop valids were given (0 = never).
    int m_period, m_rdy_from, m_err_until, m_lat, m_drop;
    int attempt, vld_cnt, lock_cd, vld_cd;
    bit in_rst, seen_run;

    initial begin
        m_period = 0; m_rdy_from = 0; m_err_until = 0; m_lat = 0; m_drop = 0;
        attempt = 0; vld_cnt = 0; lock_cd = -1; vld_cd = -1; in_rst = 0; seen_run = 0;
        forever begin
            @(negedge clk);
            stb_valid_i = 1'b0;
            if (!gen_arst_o) begin
                rdy_i = 1'b0; err_i = 1'b0;
                lock_cd = -1; vld_cd = -1; vld_cnt = 0; seen_run = 0;
                if (!in_rst) attempt++;
                in_rst = 1;
            end else begin
                in_rst = 0;
                if (run_det_o) begin
                    seen_run = 1;
                end else if (seen_run) begin
                    seen_run = 0;
                    if (m_rdy_from != 0 && attempt >= m_rdy_from) lock_cd = 3;
                end
                if (lock_cd == 0) begin
                    rdy_i = 1'b1;
                    err_i = (attempt <= m_err_until);
                    stb_period_i = TW'(m_period);
                    lock_cd = -1;
                end else if (lock_cd > 0) begin
                    lock_cd--;
                end
                if (stb_req_o) begin
                    if (m_drop != 0 && vld_cnt == m_drop) rdy_i = 1'b0;
                    else vld_cd = m_lat;
                end
                if (vld_cd == 0) begin
                    stb_valid_i = 1'b1;
                    vld_cnt++;
                    vld_cd = -1;
                end else if (vld_cd > 0) begin
                    vld_cd--;
                end
            end
        end
    end

    // Output monitor: strobe/done pulse counts and last low/high run lengths.
    int req_cnt, done_cnt, rst_run, run_run, last_rst_len, last_run_len;
    initial begin
        req_cnt = 0; done_cnt = 0; rst_run = 0; run_run = 0; last_rst_len = 0; last_run_len = 0;
        forever begin
            @(negedge clk);
            if (stb_req_o) req_cnt++;
            if (done_o) done_cnt++;
            if (!gen_arst_o) rst_run++;
            else if (rst_run > 0) begin last_rst_len = rst_run; rst_run = 0; end
            if (run_det_o) run_run++;
            else if (run_run > 0) begin last_run_len = run_run; run_run = 0; end
        end
    end

    typedef struct {
        int nstb; int tmo; int period; int rdy_from; int err_until; int lat; int drop;
        bit e_fail; int e_code; bit e_vld; int e_period; int e_cnt; int e_att; int e_req; int e_done;
    } row_t;
    row_t rows[6];

    task automatic wait_idle(input int budget, input string name);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (!busy_o) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk({name, "_end_tmo"}, 64'(busy_o), 64'd0);
    endtask

    task automatic run_row(input int r);
        row_t v = rows[r];
        string nm = $sformatf("r%0d", r);
        m_period = v.period; m_rdy_from = v.rdy_from; m_err_until = v.err_until;
        m_lat = v.lat; m_drop = v.drop;
        cfg_nstb_i = CW'(v.nstb);
        cfg_timeout_i = TW'(v.tmo);
        attempt = 0; req_cnt = 0; done_cnt = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        // The controller must run on the values captured at start.
        cfg_nstb_i = CW'(9);
        cfg_timeout_i = TW'(3);
        wait_idle(6000, nm);
        @(negedge clk);
        chk({nm, "_oe_off"}, 64'(oe_o), 64'd0);
        chk({nm, "_req_off"}, 64'(stb_req_o), 64'd0);
        chk({nm, "_run_off"}, 64'(run_det_o), 64'd0);
        chk({nm, "_grst_off"}, 64'(gen_arst_o), 64'd1);
        repeat (40) @(negedge clk);
        chk({nm, "_fail"}, 64'(fail_o), 64'(v.e_fail));
        chk({nm, "_code"}, 64'(fail_code_o), 64'(v.e_code));
        chk({nm, "_pvld"}, 64'(period_vld_o), 64'(v.e_vld));
        chk({nm, "_period"}, 64'(period_o), 64'(v.e_period));
        chk({nm, "_stbcnt"}, 64'(stb_cnt_o), 64'(v.e_cnt));
        chk({nm, "_attempts"}, 64'(attempt), 64'(v.e_att));
        chk({nm, "_reqs"}, 64'(req_cnt), 64'(v.e_req));
        chk({nm, "_dones"}, 64'(done_cnt), 64'(v.e_done));
        chk({nm, "_rst_len"}, 64'(last_rst_len), 64'd4);
        chk({nm, "_run_len"}, 64'(last_run_len), 64'd42);
    endtask

    initial begin
        //          nstb tmo period rdy err lat drop | fail code vld period cnt att req done
        rows[0] = '{5,   0,  2500,  1,  0,  2,  0,     0,   0,   1,  2500,  5,  1,  5,  1};
        rows[1] = '{5,   100, 9999, 0,  0,  2,  0,     1,   1,   0,  2500,  0,  4,  0,  0};
        rows[2] = '{3,   0,  1234,  1,  1,  0,  0,     0,   0,   1,  1234,  3,  2,  3,  1};
        rows[3] = '{0,   0,  777,   1,  0,  1,  10,    1,   3,   1,  777,   10, 1,  11, 0};
        rows[4] = '{4,   20, 555,   1,  0,  30, 0,     1,   1,   1,  555,   0,  1,  1,  0};
        rows[5] = '{2,   0,  4321,  1,  7,  0,  0,     1,   2,   0,  555,   0,  4,  0,  0};

        repeat (3) @(negedge clk);
        chk("rst_grst", 64'(gen_arst_o), 64'd0);
        chk("rst_outs", 64'({run_det_o, oe_o, stb_req_o, busy_o, done_o, fail_o, period_vld_o}), 64'd0);
        chk("rst_code", 64'(fail_code_o), 64'd0);
        chk("rst_period", 64'(period_o), 64'd0);
        chk("rst_stbcnt", 64'(stb_cnt_o), 64'd0);
        chk("rst_state", 64'(dbg_state_o), 64'(IDLE));
        arst_i = 1'b1;
        @(negedge clk);
        chk("rel_grst", 64'(gen_arst_o), 64'd1);

        for (int r = 0; r < 6; r++) run_row(r);

        // Abort in the middle of the detection window.
        m_rdy_from = 1; m_err_until = 0; m_lat = 2; m_drop = 0; m_period = 2500;
        cfg_nstb_i = CW'(5); cfg_timeout_i = '0;
        done_cnt = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 20 && !run_det_o; k++) @(negedge clk);
        chk("ab_in_arm", 64'(run_det_o), 64'd1);
        repeat (5) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        @(negedge clk);
        chk("ab_state", 64'(dbg_state_o), 64'(IDLE));
        chk("ab_ctrls", 64'({run_det_o, oe_o, stb_req_o, busy_o}), 64'd0);
        chk("ab_grst", 64'(gen_arst_o), 64'd1);
        chk("ab_nodone", 64'(done_cnt), 64'd0);
        chk("ab_nofail", 64'(fail_o), 64'd0);
        chk("ab_period_kept", 64'(period_o), 64'd555);

        // Abort together with start is not a start.
        start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        chk("abst_busy", 64'(busy_o), 64'd0);
        chk("abst_state", 64'(dbg_state_o), 64'(IDLE));
        @(negedge clk);
        chk("abst_grst", 64'(gen_arst_o), 64'd1);

        run_row(0);

        // Reset while waiting for a valid that never comes.
        m_rdy_from = 1; m_err_until = 0; m_lat = 100000; m_drop = 0; m_period = 2500;
        cfg_nstb_i = CW'(5); cfg_timeout_i = '0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 400 && !oe_o; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("mr_in_wait_vld", 64'(dbg_state_o), 64'(WAIT_VLD));
        #2 arst_i = 1'b0;
        #1;
        chk("mr_grst", 64'(gen_arst_o), 64'd0);
        chk("mr_outs", 64'({run_det_o, oe_o, stb_req_o, busy_o, done_o, fail_o, period_vld_o}), 64'd0);
        chk("mr_period", 64'(period_o), 64'd0);
        chk("mr_state", 64'(dbg_state_o), 64'(IDLE));
        @(negedge clk);
        arst_i = 1'b1;
        @(negedge clk);
        chk("mr_rel_grst", 64'(gen_arst_o), 64'd1);
        chk("mr_rel_state", 64'(dbg_state_o), 64'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/stb_seq_ctrl.md
# stb_seq_ctrl

Sequencing controller for one `stb_gen` strobe generator in the measure unit. On a start command it resets the generator, opens a period-detection window, waits for lock with timeout and retry, and latches the measured period. It then enables the strobe output and issues a programmed number of strobe requests, reporting done/fail status to the control register block.

## Interface
Parameters:
- `T_CNT_WIDTH`, 32, width of the period count and timeout.
- `CNT_WIDTH`, 16, width of the strobe-count and strobe counter.
- `RST_CYC`, 4, generator reset pulse length in clocks, ≥1.
- `RUN_CYC`, 42, detection window (`run_det_o` high) in clocks, ≥1.
- `MAX_RETRY`, 3, detection attempts after the first before fail, 0..7.

Ports:
- `clk_i`  in  1  single clock domain.
- `arst_i`  in  1  asynchronous reset, active-low.
- `start_i`  in  1  start a sequence; sampled high for one clock.
- `abort_i`  in  1  abort the sequence; highest priority.
- `cfg_nstb_i`  in  CNT_WIDTH  strobes to request; 0 means continuous until abort.
- `cfg_timeout_i`  in  T_CNT_WIDTH  clocks allowed per wait; 0 means no timeout.
- `gen_arst_o`  out  1  active-low reset to the generator.
- `run_det_o`  out  1  generator detection enable.
- `oe_o`  out  1  generator strobe output enable.
- `stb_req_o`  out  1  one-clock strobe request pulse.
- `rdy_i`  in  1  generator locked.
- `err_i`  in  1  generator error.
- `stb_valid_i`  in  1  generator acknowledges one request.
- `stb_period_i`  in  T_CNT_WIDTH  measured period in clocks.
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  one-clock pulse when the sequence finishes.
- `fail_o`  out  1  sticky fail flag; cleared by `start_i`.
- `fail_code_o`  out  2  0 none, 1 timeout, 2 detect error, 3 lock lost.
- `period_o`  out  T_CNT_WIDTH  latched period.
- `period_vld_o`  out  1  `period_o` is valid.
- `stb_cnt_o`  out  CNT_WIDTH  acknowledged strobes in the current run.

## Operation
States: IDLE, GRST, ARM, WAIT_RDY, REQ, WAIT_VLD, DONE, FAIL.
- IDLE/DONE/FAIL + `start_i` → GRST. On entry: clear `fail_o`, `fail_code_o`, `period_vld_o`, `stb_cnt_o`, and the retry counter. In other states `start_i` is ignored.
- GRST: `gen_arst_o`=0 for `RST_CYC` clocks → ARM.
- ARM: `run_det_o`=1 for `RUN_CYC` clocks → WAIT_RDY.
- WAIT_RDY: the timeout counter runs.
  - `rdy_i`=1 with `err_i`=0: latch `stb_period_i` into `period_o`, set `period_vld_o`, → REQ.
  - `err_i`=1 (error wins over ready in the same clock), or timeout: if retries < `MAX_RETRY`, increment retries and go → GRST; else → FAIL with code 2 or 1.
- REQ: `oe_o`=1, pulse `stb_req_o` for one clock → WAIT_VLD.
- WAIT_VLD: `oe_o`=1, the timeout counter runs.
  - `stb_valid_i`: increment `stb_cnt_o`; if the count equals `cfg_nstb_i` (nonzero) → DONE, else → REQ.
  - `err_i`, or `rdy_i` falling low → FAIL code 3.
  - Timeout → FAIL code 1.
- DONE: `done_o` pulses once on entry; `oe_o`=0; hold.
- FAIL: `fail_o`=1; all generator controls inactive; hold.
- `abort_i` in any state → IDLE next clock. No done or fail is reported, and `period_o` is kept. Abort beats a simultaneous `start_i`.
- Arithmetic:
  - `stb_cnt_o` saturates at all-ones in continuous mode.
  - The timeout counter reloads on entry to WAIT_RDY and WAIT_VLD and expires when count == `cfg_timeout_i`.
  - `cfg_*` inputs are sampled at the start-accept clock and held internally.

## Timing
- Reset values: `gen_arst_o`=0 (generator held in reset), all other outputs 0, state IDLE. `gen_arst_o` goes high on the first clock after reset release.
- All outputs are registered. `start_i` accepted at edge N gives `gen_arst_o`=0 from N+1 through N+`RST_CYC`.
- `run_det_o` is high for exactly `RUN_CYC` clocks, immediately after GRST.
- `stb_req_o` follows `stb_valid_i` by 2 clocks; there is at most one outstanding request.
- `stb_valid_i` arriving in the same clock as `stb_req_o` is counted.
- Reset asserted mid-run forces all outputs to their reset values asynchronously.

## Structure
- Package `stb_seq_pkg`:
  - state enum `stb_seq_state_e`;
  - fail-code enum `stb_fail_e` (FAIL_NONE, FAIL_TMO, FAIL_DET, FAIL_LOST).
- One sub-module, `stb_seq_timer`: a loadable up-counter with terminal compare, used for the GRST, ARM and timeout phases. Everything else stays in the single FSM.

## Test plan
- Start with `cfg_nstb_i`=5 and a generator model that locks with period 2500 → `period_o`=2500, five `stb_req_o`/`stb_valid_i` pairs, `done_o` pulse, `stb_cnt_o`=5, `fail_o`=0.
- Model never asserts `rdy_i`, `cfg_timeout_i`=100, `MAX_RETRY`=3 → exactly 4 GRST/ARM cycles, then FAIL with code 1.
- `err_i` high together with `rdy_i` on the first attempt, clean on the second → one retry, `period_vld_o`=1, then normal strobes.
- `cfg_nstb_i`=0; drop `rdy_i` after 10 strobes → FAIL code 3, `oe_o`=0 next clock, `stb_cnt_o`=10.
- `abort_i` during ARM, and again together with `start_i` → IDLE, no `done_o`, all controls 0; the next `start_i` runs normally.
- Assert reset mid-WAIT_VLD → all outputs at reset values immediately; after release, `gen_arst_o`=1 on the next clock and state is IDLE.
